// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM states, APB address map and AHB transfer codes for the AHB-to-APB bridge
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    localparam logic [31:0] APB_BASE     = 32'h8000_0000;
    localparam logic [31:0] APB_REGION   = 32'h0400_0000;
    localparam int          APB_NREGIONS = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_sel_decode.sv
// apb_sel_decode: maps an address onto the one-hot APB slave select; addresses outside the map select nothing
module apb_sel_decode
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NSLV   = APB_NREGIONS
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NSLV-1:0]   sel
);

    for (genvar i = 0; i < NSLV; i++) begin : g_sel
        localparam logic [63:0] LO = 64'(APB_BASE) + 64'(i) * 64'(APB_REGION);
        assign sel[i] = (64'(addr) >= LO) && (64'(addr) < LO + 64'(APB_REGION));
    end

endmodule

// File: rtl/apb_controller_fsm.sv
// apb_controller_fsm: sequences APB SETUP/ENABLE phases from pipelined AHB address/data history and stalls AHB via hreadyout
module apb_controller_fsm
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata1,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [NSLV-1:0]   pselx,
    output logic              penable,
    output logic              hreadyout
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] setup_addr;
    logic [DATA_W-1:0] setup_data;
    logic [NSLV-1:0]   setup_sel;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              pwrite_nxt;
    logic [NSLV-1:0]   pselx_nxt;
    logic              penable_nxt;
    logic              hreadyout_nxt;

    // Next-state: a write waits one cycle for its data; a pending write in WENABLEP is replayed from the 2-deep history
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:     state_nxt = valid ? (hwrite ? ST_WWAIT : ST_READ) : ST_IDLE;
            ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_nxt = ST_RENABLE;
            ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_nxt = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE:  state_nxt = valid ? (hwrite ? ST_WWAIT : ST_READ) : ST_IDLE;
            ST_WENABLEP: state_nxt = !hwrite_reg ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Reads use the live address; writes from WWAIT are one cycle behind, writes from WENABLEP two
    assign setup_addr = (state_nxt == ST_READ) ? haddr : (state == ST_WENABLEP ? haddr2 : haddr1);
    assign setup_data = (state == ST_WENABLEP) ? hwdata1 : hwdata;

    apb_sel_decode #(
        .ADDR_W (ADDR_W),
        .NSLV   (NSLV)
    ) u_sel_decode (
        .addr (setup_addr),
        .sel  (setup_sel)
    );

    // Output values to load on entry to the next state; ENABLE holds the SETUP values
    always_comb begin
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        pwrite_nxt    = pwrite;
        pselx_nxt     = '0;
        penable_nxt   = 1'b0;
        hreadyout_nxt = 1'b1;
        case (state_nxt)
            ST_READ: begin
                paddr_nxt     = setup_addr;
                pwrite_nxt    = 1'b0;
                pselx_nxt     = setup_sel;
                hreadyout_nxt = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                paddr_nxt     = setup_addr;
                pwdata_nxt    = setup_data;
                pwrite_nxt    = 1'b1;
                pselx_nxt     = setup_sel;
                hreadyout_nxt = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                pselx_nxt   = pselx;
                penable_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered APB/AHB outputs; reset aborts any transfer in flight
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            pselx     <= '0;
            penable   <= 1'b0;
            hreadyout <= 1'b1;
        end else begin
            state     <= state_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            pwrite    <= pwrite_nxt;
            pselx     <= pselx_nxt;
            penable   <= penable_nxt;
            hreadyout <= hreadyout_nxt;
        end
    end

endmodule

// File: tb/tb_apb_controller_fsm.sv
// tb_apb_controller_fsm: randomized AHB-side stimulus, expected APB transfers queued at issue and checked by a monitor
module tb_apb_controller_fsm;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        valid = 1'b0;
    logic        hwrite = 1'b0;
    logic        hwrite_reg;
    logic [31:0] haddr = '0;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata = '0;
    logic [31:0] hwdata1;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [2:0]  pselx;
    logic        penable;
    logic        hreadyout;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [2:0]  sel;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        pend_ok = 1'b0;
    logic [31:0] pend_d = '0;

    always #5 hclk = ~hclk;

    apb_controller_fsm #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .valid      (valid),
        .haddr      (haddr),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .hwdata     (hwdata),
        .hwdata1    (hwdata1),
        .hwrite     (hwrite),
        .hwrite_reg (hwrite_reg),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .pselx      (pselx),
        .penable    (penable),
        .hreadyout  (hreadyout)
    );

    // AHB slave-side history registers feeding the controller
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1 <= '0; haddr2 <= '0; hwdata1 <= '0; hwrite_reg <= 1'b0;
        end else begin
            haddr1 <= haddr; haddr2 <= haddr1; hwdata1 <= hwdata; hwrite_reg <= hwrite;
        end
    end

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
            return 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
        return 3'b000;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
        if ($urandom_range(0, 9) == 0) a = 32'h9000_0000 | ($urandom & 32'h0000_FFFC);
        return a;
    endfunction

    // Monitor: every SETUP (hreadyout low) pops one expected transfer; the following cycle must be its ENABLE
    logic        in_setup = 1'b0;
    logic [31:0] s_addr, s_data;
    logic        s_wr;
    logic [2:0]  s_sel;
    always @(negedge hclk) begin
        exp_t e;
        if (!hresetn) begin
            in_setup = 1'b0;
        end else if (in_setup) begin
            chk("enable_penable", penable, 1);
            chk("enable_hreadyout", hreadyout, 1);
            chk("enable_paddr", paddr, s_addr);
            chk("enable_pselx", pselx, s_sel);
            chk("enable_pwrite", pwrite, s_wr);
            chk("enable_pwdata", pwdata, s_data);
            in_setup = 1'b0;
        end else if (!hreadyout) begin
            chk("setup_penable", penable, 0);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_setup: got paddr %0h expected no transfer", paddr);
            end else begin
                e = q.pop_front();
                chk("setup_cycle", 64'(cyc), 64'(e.cyc));
                chk("setup_paddr", paddr, e.addr);
                chk("setup_pwrite", pwrite, e.wr);
                chk("setup_pselx", pselx, e.sel);
                if (e.wr) chk("setup_pwdata", pwdata, e.data);
            end
            s_addr = paddr; s_data = pwdata; s_wr = pwrite; s_sel = pselx;
            in_setup = 1'b1;
        end else begin
            chk("idle_penable", penable, 0);
            chk("idle_pselx", pselx, 0);
        end
    end

    // One AHB cycle: address phase now, write data follows one cycle later and is held until replaced
    task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d);
        if (pend_ok) hwdata = pend_d;
        pend_ok = v && w;
        pend_d = d;
        valid = v;
        if (v) begin
            haddr = a;
            hwrite = w;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic w, input int c);
        exp_t e;
        e.addr = a; e.data = d; e.wr = w; e.sel = ref_sel(a); e.cyc = c;
        q.push_back(e);
    endtask

    // kind 0 read, 1 write, 2 write+write, 3 write+read; SETUP latency follows the documented pipeline
    task automatic item(input int kind, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input int gap);
        case (kind)
            0: begin push(a0, 0, 0, cyc + 1); drive(1, a0, 0, 0); end
            1: begin push(a0, d0, 1, cyc + 2); drive(1, a0, 1, d0); end
            2: begin
                push(a0, d0, 1, cyc + 2); push(a1, d1, 1, cyc + 4);
                drive(1, a0, 1, d0); drive(1, a1, 1, d1);
            end
            default: begin
                push(a0, d0, 1, cyc + 2); push(a1, 0, 0, cyc + 4);
                drive(1, a0, 1, d0); drive(1, a1, 0, 0);
            end
        endcase
        repeat (gap) drive(0, 0, 0, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_pselx"}, pselx, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_hreadyout"}, hreadyout, 1);
    endtask

    initial begin
        repeat (3) @(posedge hclk);
        #1;
        chk_reset("reset");
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        item(0, 32'h8000_0010, 0, 0, 0, 3);
        item(1, 32'h8400_0004, 0, 32'hA5A5_0001, 0, 3);
        item(2, 32'h8800_0000, 32'h8800_0004, 32'h11, 32'h22, 3);
        item(3, 32'h8000_0000, 32'h8400_0008, 32'h33, 0, 3);
        item(0, 32'h9000_0000, 0, 0, 0, 3);
        item(1, 32'h9000_0000, 0, 32'h44, 0, 3);
        // Abort a pipelined write pair while its first SETUP is on the bus
        drive(1, 32'h8400_0100, 1, 32'h55);
        drive(1, 32'h8400_0104, 1, 32'h66);
        valid = 1'b0;
        hwdata = 32'h66;
        pend_ok = 1'b0;
        #1;
        chk("pre_abort_hreadyout", hreadyout, 0);
        chk("pre_abort_paddr", paddr, 32'h8400_0100);
        chk("pre_abort_pselx", pselx, 3'b010);
        hresetn = 1'b0;
        #1;
        chk_reset("async_reset");
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        item(0, 32'h8800_0020, 0, 0, 0, 3);
        for (int n = 0; n < 60; n++)
            item($urandom_range(0, 3), rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom_range(3, 6));
        repeat (10) drive(0, 0, 0, 0);
        chk("drain_queue_empty", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
